// File: rtl/decode_operand_latch_pkg.sv
// rtl/decode_operand_latch_pkg.sv - shared types and constants for the decode/execute operand latch
//
// Purpose : holds the load-use FSM encoding, the bypass flag bit positions,
//           the NOP/bubble word and a small hazard helper shared by the
//           top level and the operand bypass mux.
// Ports   : none (package).
package decode_operand_latch_pkg;

  // Load-use stall sequencer states.
  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU1 = 2'd1,
    ST_LU2 = 2'd2
  } lu_state_e;

  // Bit positions inside the 3-bit bypass match flags.
  localparam int unsigned BYP_DE = 2;  // destination of the D/X instruction
  localparam int unsigned BYP_EM = 1;  // destination of the X/M instruction
  localparam int unsigned BYP_MW = 0;  // destination of the M/W instruction

  // Word loaded into D/X when a bubble is inserted.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Saturation ceiling of the stall cycle counter.
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // A source only depends on the D/X result when it names a real register
  // (index 0 is hardwired zero and never creates a dependency).
  function automatic logic src_hits_de(input logic [4:0] idx, input logic [2:0] sig);
    return (idx != 5'd0) && sig[BYP_DE];
  endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// rtl/operand_bypass_mux.sv - per-side forwarding mux selecting one source operand
//
// Purpose : picks the operand value for one source register of the F/D
//           instruction, honouring forwarding from later pipeline stages.
// Ports   : src_idx    in  5   source register index
//           bypass_sig in  3   match flags (bit2 D/X, bit1 X/M, bit0 M/W)
//           rf_data    in  32  register file read data
//           x_result   in  32  D/X stage result
//           m_result   in  32  X/M stage result
//           w_data     in  32  M/W stage result
//           operand    out 32  selected operand
module operand_bypass_mux
  import decode_operand_latch_pkg::*;
(
  input  logic [4:0]  src_idx,
  input  logic [2:0]  bypass_sig,
  input  logic [31:0] rf_data,
  input  logic [31:0] x_result,
  input  logic [31:0] m_result,
  input  logic [31:0] w_data,
  output logic [31:0] operand
);

  // The youngest producing stage wins; register 0 always reads as zero even
  // if a stale match flag claims otherwise.
  always_comb begin
    operand = rf_data;
    if (src_idx == 5'd0) begin
      operand = 32'h0;
    end else if (bypass_sig[BYP_DE]) begin
      operand = x_result;
    end else if (bypass_sig[BYP_EM]) begin
      operand = m_result;
    end else if (bypass_sig[BYP_MW]) begin
      operand = w_data;
    end
  end

endmodule

// File: rtl/decode_operand_latch.sv
// rtl/decode_operand_latch.sv - D/X pipeline latch with operand forwarding and load-use stall
//
// Purpose : captures the F/D instruction and its forwarded operands into the
//           D/X register, inserts two extra bubbles after a load-use hazard,
//           freezes while execute is busy and kills F/D on a taken branch.
// Ports   : clock, reset                 in      clock / async active-high reset
//           fd_instruction, fd_valid     in      F/D latch contents
//           fd_reg_S1, fd_reg_S2         in  5   source indices
//           bypass_A_sig, bypass_B_sig   in  3   forwarding match flags
//           rf_data_A, rf_data_B         in  32  register file read data
//           x_result, m_result, w_data   in  32  later-stage results
//           de_is_load, x_busy, flush    in      hazard / freeze / kill controls
//           stall_fd                     out     hold PC and F/D
//           de_instruction, de_operand_A, de_operand_B, de_valid   out  D/X contents
//           stall_cycles                 out 16  saturating stall counter
module decode_operand_latch
  import decode_operand_latch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_instruction,
  input  logic        fd_valid,
  input  logic [4:0]  fd_reg_S1,
  input  logic [4:0]  fd_reg_S2,
  input  logic [2:0]  bypass_A_sig,
  input  logic [2:0]  bypass_B_sig,
  input  logic [31:0] rf_data_A,
  input  logic [31:0] rf_data_B,
  input  logic [31:0] x_result,
  input  logic [31:0] m_result,
  input  logic [31:0] w_data,
  input  logic        de_is_load,
  input  logic        x_busy,
  input  logic        flush,
  output logic        stall_fd,
  output logic [31:0] de_instruction,
  output logic [31:0] de_operand_A,
  output logic [31:0] de_operand_B,
  output logic        de_valid,
  output logic [15:0] stall_cycles
);

  lu_state_e   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        hazard;
  logic        stall_raw;

  operand_bypass_mux u_mux_a (
    .src_idx    (fd_reg_S1),
    .bypass_sig (bypass_A_sig),
    .rf_data    (rf_data_A),
    .x_result   (x_result),
    .m_result   (m_result),
    .w_data     (w_data),
    .operand    (sel_a)
  );

  operand_bypass_mux u_mux_b (
    .src_idx    (fd_reg_S2),
    .bypass_sig (bypass_B_sig),
    .rf_data    (rf_data_B),
    .x_result   (x_result),
    .m_result   (m_result),
    .w_data     (w_data),
    .operand    (sel_b)
  );

  // The load result is only usable once it reaches M/W, so a consumer that
  // matches the D/X destination of a real load must wait.
  assign hazard = fd_valid && valid_q && de_is_load &&
                  (src_hits_de(fd_reg_S1, bypass_A_sig) ||
                   src_hits_de(fd_reg_S2, bypass_B_sig));

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    valid_d   = valid_q;
    stall_raw = 1'b0;

    if (flush) begin
      // A taken branch kills whatever F/D holds, including a pending
      // load-use sequence, and lets fetch redirect immediately.
      state_d = ST_RUN;
      instr_d = NOP_WORD;
      op_a_d  = 32'h0;
      op_b_d  = 32'h0;
      valid_d = 1'b0;
    end else if (x_busy) begin
      // Execute is frozen: D/X and the sequencer hold, fetch must hold too.
      stall_raw = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            state_d   = ST_LU1;
            instr_d   = NOP_WORD;
            op_a_d    = 32'h0;
            op_b_d    = 32'h0;
            valid_d   = 1'b0;
            stall_raw = 1'b1;
          end else if (fd_valid) begin
            instr_d = fd_instruction;
            op_a_d  = sel_a;
            op_b_d  = sel_b;
            valid_d = 1'b1;
          end else begin
            instr_d = NOP_WORD;
            op_a_d  = 32'h0;
            op_b_d  = 32'h0;
            valid_d = 1'b0;
          end
        end
        ST_LU1: begin
          state_d   = ST_LU2;
          instr_d   = NOP_WORD;
          op_a_d    = 32'h0;
          op_b_d    = 32'h0;
          valid_d   = 1'b0;
          stall_raw = 1'b1;
        end
        ST_LU2: begin
          state_d   = ST_RUN;
          instr_d   = NOP_WORD;
          op_a_d    = 32'h0;
          op_b_d    = 32'h0;
          valid_d   = 1'b0;
          stall_raw = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          instr_d = NOP_WORD;
          op_a_d  = 32'h0;
          op_b_d  = 32'h0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Reset masks the stall so fetch is never held while the pipe is cleared.
  assign stall_fd = stall_raw && !reset;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_fd && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      instr_q     <= NOP_WORD;
      op_a_q      <= 32'h0;
      op_b_q      <= 32'h0;
      valid_q     <= 1'b0;
      stall_cnt_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign de_instruction = instr_q;
  assign de_operand_A   = op_a_q;
  assign de_operand_B   = op_b_q;
  assign de_valid       = valid_q;
  assign stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_decode_operand_latch.sv
// tb/tb_decode_operand_latch.sv - scoreboard bench for decode_operand_latch
module tb_decode_operand_latch;

  logic        clock;
  logic        reset;
  logic [31:0] fd_instruction;
  logic        fd_valid;
  logic [4:0]  fd_reg_S1, fd_reg_S2;
  logic [2:0]  bypass_A_sig, bypass_B_sig;
  logic [31:0] rf_data_A, rf_data_B, x_result, m_result, w_data;
  logic        de_is_load, x_busy, flush;
  logic        stall_fd;
  logic [31:0] de_instruction, de_operand_A, de_operand_B;
  logic        de_valid;
  logic [15:0] stall_cycles;

  decode_operand_latch dut (
    .clock          (clock),
    .reset          (reset),
    .fd_instruction (fd_instruction),
    .fd_valid       (fd_valid),
    .fd_reg_S1      (fd_reg_S1),
    .fd_reg_S2      (fd_reg_S2),
    .bypass_A_sig   (bypass_A_sig),
    .bypass_B_sig   (bypass_B_sig),
    .rf_data_A      (rf_data_A),
    .rf_data_B      (rf_data_B),
    .x_result       (x_result),
    .m_result       (m_result),
    .w_data         (w_data),
    .de_is_load     (de_is_load),
    .x_busy         (x_busy),
    .flush          (flush),
    .stall_fd       (stall_fd),
    .de_instruction (de_instruction),
    .de_operand_A   (de_operand_A),
    .de_operand_B   (de_operand_B),
    .de_valid       (de_valid),
    .stall_cycles   (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
    logic [15:0] sc;
  } rec_t;

  rec_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] sc_exp = 16'h0;

  localparam logic [31:0] I1 = 32'h1111_0001, I2 = 32'h2222_0002, I3 = 32'h3333_0003;
  localparam logic [31:0] I4 = 32'h4444_0004, I5 = 32'h5555_0005, I6 = 32'h6666_0006;
  localparam logic [31:0] I7 = 32'h7777_0007, I8 = 32'h8888_0008, I9 = 32'h9999_0009;
  localparam logic [31:0] I10 = 32'hAAAA_000A, I11 = 32'hBBBB_000B, I12 = 32'hCCCC_000C;
  localparam logic [31:0] I13 = 32'hDDDD_000D;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already applied for the coming cycle.
  task automatic cyc(input logic stall, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic v);
    rec_t r;
    if (stall && sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
    r.stall = stall; r.ins = ins; r.a = a; r.b = b; r.v = v; r.sc = sc_exp;
    exp_q.push_back(r);
    @(negedge clock);
  endtask

  task automatic bubble(input logic stall);
    cyc(stall, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Monitor: stall_fd mid low phase, D/X contents just after the rising edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clock);
      #3;
      if (exp_q.size() > 0) begin
        r = exp_q[0];
        chk("stall_fd", {31'h0, stall_fd}, {31'h0, r.stall});
        @(posedge clock);
        #1;
        r = exp_q.pop_front();
        chk("de_instruction", de_instruction, r.ins);
        chk("de_operand_A", de_operand_A, r.a);
        chk("de_operand_B", de_operand_B, r.b);
        chk("de_valid", {31'h0, de_valid}, {31'h0, r.v});
        chk("stall_cycles", {16'h0, stall_cycles}, {16'h0, r.sc});
      end
    end
  end

  initial begin
    reset = 1'b1; fd_instruction = 32'h0; fd_valid = 1'b0;
    fd_reg_S1 = 5'd0; fd_reg_S2 = 5'd0; bypass_A_sig = 3'b000; bypass_B_sig = 3'b000;
    rf_data_A = 32'd77; rf_data_B = 32'd22; x_result = 32'd5; m_result = 32'd9; w_data = 32'd13;
    de_is_load = 1'b0; x_busy = 1'b1; flush = 1'b0;
    #1;
    chk("reset_stall_fd", {31'h0, stall_fd}, 32'h0);
    chk("reset_de_valid", {31'h0, de_valid}, 32'h0);
    chk("reset_stall_cycles", {16'h0, stall_cycles}, 32'h0);
    @(negedge clock);
    chk("reset_de_instruction", de_instruction, 32'h0);
    chk("reset_stall_fd_edge", {31'h0, stall_fd}, 32'h0);
    reset = 1'b0; x_busy = 1'b0;

    // Forwarding priority and register-0 cases.
    fd_valid = 1'b1; fd_instruction = I1; fd_reg_S1 = 5'd3; bypass_A_sig = 3'b110;
    fd_reg_S2 = 5'd2; bypass_B_sig = 3'b000;
    cyc(1'b0, I1, 32'd5, 32'd22, 1'b1);
    fd_instruction = I2; fd_reg_S1 = 5'd0; bypass_A_sig = 3'b111; rf_data_A = 32'd7;
    fd_reg_S2 = 5'd5; bypass_B_sig = 3'b010;
    cyc(1'b0, I2, 32'd0, 32'd9, 1'b1);
    rf_data_A = 32'd77;
    fd_instruction = I3; fd_reg_S1 = 5'd6; bypass_A_sig = 3'b001;
    fd_reg_S2 = 5'd7; bypass_B_sig = 3'b000;
    cyc(1'b0, I3, 32'd13, 32'd22, 1'b1);
    // Empty F/D gives a bubble without stalling.
    fd_valid = 1'b0; fd_instruction = I4;
    bubble(1'b0);
    // Capture a load, then a dependent consumer on side B.
    fd_valid = 1'b1; fd_instruction = I4; fd_reg_S1 = 5'd1; bypass_A_sig = 3'b000;
    fd_reg_S2 = 5'd2; bypass_B_sig = 3'b000;
    cyc(1'b0, I4, 32'd77, 32'd22, 1'b1);
    de_is_load = 1'b1; fd_instruction = I5; fd_reg_S2 = 5'd4; bypass_B_sig = 3'b100;
    bubble(1'b1);
    bubble(1'b1);
    bubble(1'b1);
    de_is_load = 1'b0; bypass_B_sig = 3'b001;
    cyc(1'b0, I5, 32'd77, 32'd13, 1'b1);

    // Execute busy while in LU1 holds the sequencer there.
    de_is_load = 1'b1; fd_instruction = I6; fd_reg_S1 = 5'd8; bypass_A_sig = 3'b100;
    fd_reg_S2 = 5'd4; bypass_B_sig = 3'b000;
    bubble(1'b1);
    x_busy = 1'b1;
    for (int i = 0; i < 3; i++) bubble(1'b1);
    x_busy = 1'b0;
    bubble(1'b1);
    bubble(1'b1);
    de_is_load = 1'b0; bypass_A_sig = 3'b001;
    cyc(1'b0, I6, 32'd13, 32'd22, 1'b1);
    // Busy in RUN freezes captured contents.
    x_busy = 1'b1; fd_instruction = I7; bypass_A_sig = 3'b010;
    cyc(1'b1, I6, 32'd13, 32'd22, 1'b1);
    x_busy = 1'b0;
    cyc(1'b0, I7, 32'd9, 32'd22, 1'b1);

    // Flush overrides busy in LU2.
    de_is_load = 1'b1; fd_instruction = I8; bypass_A_sig = 3'b100;
    bubble(1'b1);
    bubble(1'b1);
    flush = 1'b1; x_busy = 1'b1;
    bubble(1'b0);
    flush = 1'b0; x_busy = 1'b0; de_is_load = 1'b0; bypass_A_sig = 3'b000; fd_instruction = I9;
    cyc(1'b0, I9, 32'd77, 32'd22, 1'b1);
    // Flush overrides a hazard in RUN; no hazard afterwards because D/X is empty.
    de_is_load = 1'b1; bypass_A_sig = 3'b100; flush = 1'b1; fd_instruction = I10;
    bubble(1'b0);
    flush = 1'b0;
    cyc(1'b0, I10, 32'd5, 32'd22, 1'b1);

    // Drive the counter into saturation.
    de_is_load = 1'b0; x_busy = 1'b1;
    repeat (65540) @(negedge clock);
    sc_exp = 16'hFFFF;
    x_busy = 1'b0; bypass_A_sig = 3'b000; fd_instruction = I11;
    cyc(1'b0, I11, 32'd77, 32'd22, 1'b1);
    x_busy = 1'b1;
    cyc(1'b1, I11, 32'd77, 32'd22, 1'b1);
    x_busy = 1'b0;

    // Reset in the middle of LU1.
    de_is_load = 1'b1; bypass_A_sig = 3'b100; fd_instruction = I12;
    bubble(1'b1);
    #2;
    chk("lu1_stall_fd", {31'h0, stall_fd}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_reset_stall_fd", {31'h0, stall_fd}, 32'h0);
    chk("async_reset_stall_cycles", {16'h0, stall_cycles}, 32'h0);
    chk("async_reset_de_valid", {31'h0, de_valid}, 32'h0);
    chk("async_reset_de_instruction", de_instruction, 32'h0);
    chk("async_reset_de_operand_A", de_operand_A, 32'h0);
    chk("async_reset_de_operand_B", de_operand_B, 32'h0);
    sc_exp = 16'h0;
    @(negedge clock);
    reset = 1'b0; de_is_load = 1'b0; bypass_A_sig = 3'b000; fd_instruction = I13;
    cyc(1'b0, I13, 32'd77, 32'd22, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
